// File: rtl/scm_stream_writer_pkg.sv
// rtl/scm_stream_writer_pkg.sv - shared SCM geometry and writer state encoding
package scm_stream_writer_pkg;

  localparam int unsigned ScmC             = 32;
  localparam int unsigned ScmK             = 16;
  localparam int unsigned ScmDataTypeWidth = 16;
  localparam int unsigned ScmDepth         = ScmC * ScmK;
  localparam int unsigned ScmAddrWidth     = $clog2(ScmDepth);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } writer_state_e;

endpackage

// File: rtl/scm_stream_writer_if.sv
// rtl/scm_stream_writer_if.sv - valid/ready data stream feeding the SCM writer
interface scm_stream_writer_if
  import scm_stream_writer_pkg::*;
#(
  parameter int unsigned DataTypeWidth = ScmDataTypeWidth
);

  logic                     s_valid;
  logic                     s_ready;
  logic [DataTypeWidth-1:0] s_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/scm_stream_writer_addr_cnt.sv
// rtl/scm_stream_writer_addr_cnt.sv - loadable SCM address counter wrapping at Depth-1
module scm_addr_wrap_cnt
  import scm_stream_writer_pkg::*;
#(
  parameter int unsigned Depth     = ScmDepth,
  parameter int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 load_i,
  input  logic [AddrWidth-1:0] load_addr_i,
  input  logic                 inc_i,
  output logic [AddrWidth-1:0] addr_o
);

  localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(Depth - 1);

  logic [AddrWidth-1:0] addr_q, addr_d;

  // Wrap at the real depth, not at the power-of-two address range.
  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_addr_i;
    end else if (inc_i) begin
      addr_d = (addr_q == LastAddr) ? '0 : addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/scm_stream_writer.sv
// rtl/scm_stream_writer.sv - job-driven stream to SCM write-port front end
module scm_stream_writer
  import scm_stream_writer_pkg::*;
#(
  parameter int unsigned C              = ScmC,
  parameter int unsigned K              = ScmK,
  parameter int unsigned DataTypeWidth  = ScmDataTypeWidth,
  parameter int unsigned TotalAddrWidth = $clog2(C * K),
  parameter int unsigned DrainCycles    = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  input  logic [TotalAddrWidth-1:0] base_addr_i,
  input  logic [TotalAddrWidth:0]   num_words_i,
  input  logic                      abort_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  scm_stream_writer_if.slave        s,
  output logic [TotalAddrWidth-1:0] waddr_o,
  output logic [DataTypeWidth-1:0]  wdata_o,
  output logic                      we_o
);

  localparam int unsigned Depth  = C * K;
  localparam int unsigned CntW   = TotalAddrWidth + 1;
  localparam int unsigned DrainW = (DrainCycles > 0) ? $clog2(DrainCycles + 1) : 1;

  localparam logic [CntW-1:0]   DepthCnt  = CntW'(Depth);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(DrainCycles);

  writer_state_e              state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [DrainW-1:0]          drain_q, drain_d;
  logic                       we_q, we_d;
  logic [TotalAddrWidth-1:0]  waddr_q, waddr_d;
  logic [DataTypeWidth-1:0]   wdata_q, wdata_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;

  logic                       s_ready;
  logic                       hs;
  logic                       addr_load;
  logic                       addr_inc;
  logic [TotalAddrWidth-1:0]  cur_addr;

  assign s_ready = (state_q == LOAD);
  assign hs      = s.s_valid & s_ready;

  scm_addr_wrap_cnt #(
    .Depth     (Depth),
    .AddrWidth (TotalAddrWidth)
  ) u_addr_cnt (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .load_i      (addr_load),
    .load_addr_i (base_addr_i),
    .inc_i       (addr_inc),
    .addr_o      (cur_addr)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    addr_load = 1'b0;
    addr_inc  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (num_words_i == '0) begin
            done_d = 1'b1;
          end else if (num_words_i > DepthCnt) begin
            error_d = 1'b1;
          end else begin
            addr_load = 1'b1;
            cnt_d     = num_words_i;
            state_d   = LOAD;
          end
        end
      end

      LOAD: begin
        if (hs) begin
          we_d     = 1'b1;
          waddr_d  = cur_addr;
          wdata_d  = s.s_data;
          addr_inc = 1'b1;
          cnt_d    = cnt_q - 1'b1;
        end
        // Abort wins over the final beat; the beat's write still goes out.
        if (abort_i) begin
          state_d = IDLE;
        end else if (hs && (cnt_q == CntW'(1))) begin
          state_d = DRAIN;
          drain_d = '0;
        end
      end

      DRAIN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (drain_q == DrainLast) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign s.s_ready = s_ready;
  assign busy_o    = (state_q == LOAD) || (state_q == DRAIN);
  assign done_o    = done_q;
  assign error_o   = error_q;
  assign we_o      = we_q;
  assign waddr_o   = waddr_q;
  assign wdata_o   = wdata_q;

endmodule
